// File: rtl/dmem_ctrl_pkg.sv
// Shared types for the data-memory controller: copy FSM states and the
// default RAM geometry.
package dmem_ctrl_pkg;

  localparam int DM_ADDRESS_DEF = 9;
  localparam int DEPTH          = 2 ** DM_ADDRESS_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } copy_state_e;

endpackage

// File: rtl/dmem_copy_arbiter.sv
// Data-memory port arbiter: copy engine > CPU load/store > external debug read.
// Block copies move one word per RD/WR pair with memmove ordering.
//
// state | meaning
// IDLE  | RAM port free for CPU and external reads
// RD    | copy engine reading source word src+idx
// WR    | copy engine writing that word to dst+idx
// DONE  | copy_done pulse (copy_err if the request was rejected)
module dmem_copy_arbiter
  import dmem_ctrl_pkg::*;
#(
  parameter int DM_ADDRESS = DM_ADDRESS_DEF,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_mem_read,
  input  logic                  cpu_mem_write,
  input  logic                  cpu_mem_copy,
  input  logic [DM_ADDRESS-1:0] cpu_addr,
  input  logic [DATA_W-1:0]     cpu_wdata,
  input  logic [31:0]           copy_src,
  input  logic [31:0]           copy_dst,
  input  logic [31:0]           copy_len,
  output logic [DATA_W-1:0]     cpu_rdata,
  output logic                  cpu_stall,
  input  logic                  ext_req,
  input  logic [DM_ADDRESS-1:0] ext_addr,
  output logic [DATA_W-1:0]     ext_rdata,
  output logic                  ext_valid,
  output logic [DM_ADDRESS-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic                  copy_busy,
  output logic                  copy_done,
  output logic                  copy_err
);

  localparam int          LW      = DM_ADDRESS + 1;
  localparam int          EW      = DM_ADDRESS + 2;
  localparam int unsigned N_WORDS = 2 ** DM_ADDRESS;
  localparam logic [DM_ADDRESS-1:0] IDX_ONE = 1;
  localparam logic [LW-1:0]         LEN_ONE = 1;

  copy_state_e           state_q, state_d;
  logic [DM_ADDRESS-1:0] src_q, src_d;
  logic [DM_ADDRESS-1:0] dst_q, dst_d;
  logic [DM_ADDRESS-1:0] idx_q, idx_d;
  logic [LW-1:0]         len_q, len_d;
  logic                  desc_q, desc_d;
  logic                  err_q, err_d;

  logic                  load_q, ext_pend_q;
  logic [DATA_W-1:0]     ext_hold_q;
  logic                  load_gnt, ext_gnt;

  logic [DM_ADDRESS-1:0] req_src, req_dst;
  logic [EW-1:0]         req_end;
  logic                  len_zero, len_big, req_desc;
  logic                  copy_start, last_word;
  logic                  unused_hi;

  assign req_src  = copy_src[DM_ADDRESS-1:0];
  assign req_dst  = copy_dst[DM_ADDRESS-1:0];
  assign len_zero = (copy_len == 32'd0);
  assign len_big  = (copy_len > 32'(N_WORDS));
  // Overlap test is done on unwrapped addresses, so the end may exceed DEPTH.
  assign req_end  = EW'(req_src) + EW'(copy_len[LW-1:0]);
  assign req_desc = (req_dst > req_src) && (EW'(req_dst) < req_end);
  assign unused_hi = ^{copy_src[31:DM_ADDRESS], copy_dst[31:DM_ADDRESS]};

  assign copy_start = (state_q == IDLE) && cpu_mem_copy;
  assign last_word  = desc_q ? (idx_q == '0) : ({1'b0, idx_q} == (len_q - LEN_ONE));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    idx_d   = idx_q;
    len_d   = len_q;
    desc_d  = desc_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (cpu_mem_copy) begin
          if (len_zero || len_big) begin
            state_d = DONE;
            err_d   = len_big;
          end else begin
            state_d = RD;
            src_d   = req_src;
            dst_d   = req_dst;
            len_d   = copy_len[LW-1:0];
            desc_d  = req_desc;
            idx_d   = req_desc ? (copy_len[DM_ADDRESS-1:0] - IDX_ONE) : '0;
            err_d   = 1'b0;
          end
        end
      end
      RD: state_d = WR;
      WR: begin
        if (last_word) begin
          state_d = DONE;
        end else begin
          state_d = RD;
          idx_d   = desc_q ? (idx_q - IDX_ONE) : (idx_q + IDX_ONE);
        end
      end
      DONE: begin
        state_d = IDLE;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
      desc_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      desc_q  <= desc_d;
      err_q   <= err_d;
    end
  end

  // A copy request cycle blocks the port too: the load/store is dropped and
  // an external read must not slip in ahead of the copy.
  always_comb begin
    ram_addr  = '0;
    ram_we    = 1'b0;
    ram_wdata = '0;
    load_gnt  = 1'b0;
    ext_gnt   = 1'b0;
    if (state_q == RD) begin
      ram_addr = src_q + idx_q;
    end else if (state_q == WR) begin
      ram_addr  = dst_q + idx_q;
      ram_we    = 1'b1;
      ram_wdata = ram_rdata;
    end else if (!copy_start) begin
      if (cpu_mem_write) begin
        ram_addr  = cpu_addr;
        ram_we    = 1'b1;
        ram_wdata = cpu_wdata;
      end else if (cpu_mem_read) begin
        ram_addr = cpu_addr;
        load_gnt = 1'b1;
      end else if (ext_req && !ext_pend_q) begin
        ram_addr = ext_addr;
        ext_gnt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q     <= 1'b0;
      ext_pend_q <= 1'b0;
      ext_hold_q <= '0;
    end else begin
      load_q     <= load_gnt;
      ext_pend_q <= ext_gnt;
      if (ext_pend_q) ext_hold_q <= ram_rdata;
    end
  end

  // CPU accesses only lose the port to RD/WR or a same-cycle copy request,
  // all of which already stall.
  assign cpu_stall = copy_start || (state_q == RD) || (state_q == WR);
  assign cpu_rdata = load_q ? ram_rdata : '0;
  assign ext_valid = ext_pend_q;
  assign ext_rdata = ext_pend_q ? ram_rdata : ext_hold_q;
  assign copy_busy = (state_q != IDLE);
  assign copy_done = (state_q == DONE);
  assign copy_err  = (state_q == DONE) && err_q;

endmodule

// File: tb/tb_dmem_copy_arbiter.sv
// Scoreboard bench: stimulus pushes expectations, a negedge monitor pops and
// compares; memory contents are checked against a word-array reference model.
module tb_dmem_copy_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;
  localparam int NW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cpu_mem_read, cpu_mem_write, cpu_mem_copy;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic [31:0]   copy_src, copy_dst, copy_len;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_stall;
  logic          ext_req;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_rdata;
  logic          ext_valid;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;
  logic          copy_busy, copy_done, copy_err;

  always #5 clk = ~clk;

  dmem_copy_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_mem_read(cpu_mem_read), .cpu_mem_write(cpu_mem_write), .cpu_mem_copy(cpu_mem_copy),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .copy_src(copy_src), .copy_dst(copy_dst), .copy_len(copy_len),
    .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ext_req(ext_req), .ext_addr(ext_addr), .ext_rdata(ext_rdata), .ext_valid(ext_valid),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .copy_busy(copy_busy), .copy_done(copy_done), .copy_err(copy_err)
  );

  // Single-port synchronous RAM, one cycle read latency.
  logic [DW-1:0] sram [NW];
  always @(posedge clk) begin
    if (ram_we) sram[ram_addr] <= ram_wdata;
    ram_rdata <= sram[ram_addr];
  end

  typedef struct { int cyc; logic [DW-1:0] data; } exp_t;
  typedef struct { int cyc; logic err; } exp_c_t;

  exp_t   exp_ld[$];
  exp_t   exp_ext[$];
  exp_c_t exp_cp[$];
  logic [DW-1:0] ref_mem [NW];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int st_lo = -1, st_hi = -2, bz_lo = -1, bz_hi = -2;
  int last_done = 0;
  bit no_we = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(bit ok, string name, longint act, longint exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
    end
  endfunction

  exp_t   mon_e;
  exp_c_t mon_c;
  always @(negedge clk) begin
    if (rst_n) begin
      if (copy_done) begin
        if (exp_cp.size() == 0) chk(1'b0, "copy_done_unexpected", 1, 0);
        else begin
          mon_c = exp_cp.pop_front();
          chk(cyc == mon_c.cyc, "copy_done_cycle", cyc, mon_c.cyc);
          chk(copy_err == mon_c.err, "copy_err", copy_err, mon_c.err);
        end
      end else if (exp_cp.size() != 0 && cyc > exp_cp[0].cyc) begin
        chk(1'b0, "copy_done_missing", cyc, exp_cp[0].cyc);
        void'(exp_cp.pop_front());
      end
      chk(cpu_stall == (cyc >= st_lo && cyc <= st_hi), "cpu_stall", cpu_stall,
          (cyc >= st_lo && cyc <= st_hi));
      chk(copy_busy == (cyc >= bz_lo && cyc <= bz_hi), "copy_busy", copy_busy,
          (cyc >= bz_lo && cyc <= bz_hi));
      if (exp_ld.size() != 0 && exp_ld[0].cyc == cyc) begin
        mon_e = exp_ld.pop_front();
        chk(cpu_rdata == mon_e.data, "cpu_rdata", cpu_rdata, mon_e.data);
      end else begin
        chk(cpu_rdata == '0, "cpu_rdata_idle", cpu_rdata, 0);
      end
      if (ext_valid) begin
        if (exp_ext.size() == 0) chk(1'b0, "ext_valid_unexpected", 1, 0);
        else begin
          mon_e = exp_ext.pop_front();
          chk(ext_rdata == mon_e.data, "ext_rdata", ext_rdata, mon_e.data);
          chk(cyc == mon_e.cyc, "ext_valid_cycle", cyc, mon_e.cyc);
        end
      end
      if (no_we) chk(!ram_we, "ram_we_quiet", ram_we, 0);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_cycle(bit rd, bit wr, logic [AW-1:0] a, logic [DW-1:0] d);
    exp_t e;
    tick();
    cpu_mem_copy  = 1'b0;
    cpu_mem_read  = rd;
    cpu_mem_write = wr;
    cpu_addr      = a;
    cpu_wdata     = d;
    if (wr) ref_mem[a] = d;
    else if (rd) begin
      e.cyc  = cyc + 1;
      e.data = ref_mem[a];
      exp_ld.push_back(e);
    end
  endtask

  // Reference copy: word moves in ascending order, or descending when the
  // destination starts inside the (unwrapped) source range.
  function automatic void model_copy(int src, int dst, int n, int words);
    bit desc;
    int i;
    desc = (dst > src) && (dst < src + n);
    for (int k = 0; k < words; k++) begin
      i = desc ? (n - 1 - k) : k;
      ref_mem[(dst + i) % NW] = ref_mem[(src + i) % NW];
    end
  endfunction

  task automatic do_copy(int src, int dst, logic [31:0] len, bit with_ls);
    int n, t;
    bit bad;
    exp_c_t c;
    bad = (len > NW);
    n = (bad || len == 0) ? 0 : int'(len);
    tick();
    t = cyc;
    cpu_mem_copy  = 1'b1;
    copy_src      = ($urandom() & 32'hFFFF_FE00) | 32'(src);
    copy_dst      = ($urandom() & 32'hFFFF_FE00) | 32'(dst);
    copy_len      = len;
    cpu_mem_read  = 1'b0;
    cpu_mem_write = with_ls;
    cpu_addr      = AW'($urandom());
    cpu_wdata     = $urandom();
    c.cyc = t + 2 * n + 1;
    c.err = bad;
    exp_cp.push_back(c);
    last_done = c.cyc;
    st_lo = t;     st_hi = t + 2 * n;
    bz_lo = t + 1; bz_hi = t + 2 * n + 1;
    no_we = (n == 0);
    model_copy(src, dst, n, n);
    tick();
    cpu_mem_copy  = 1'b0;
    cpu_mem_write = 1'b0;
    copy_src      = $urandom();
    copy_dst      = $urandom();
    copy_len      = $urandom();
    for (int k = 0; k < 2 * n + 8 && exp_cp.size() != 0; k++) @(negedge clk);
    if (exp_cp.size() != 0) begin
      chk(1'b0, "copy_timeout", exp_cp.size(), 0);
      exp_cp.delete();
    end
    no_we = 1'b0;
  endtask

  task automatic ext_read(logic [AW-1:0] a, bit after_copy);
    exp_t e;
    bit got;
    got = 1'b0;
    tick();
    if (!after_copy) begin
      cpu_mem_read  = 1'b0;
      cpu_mem_write = 1'b0;
    end
    ext_req  = 1'b1;
    ext_addr = a;
    e.cyc  = after_copy ? last_done + 1 : cyc + 1;
    e.data = ref_mem[a];
    exp_ext.push_back(e);
    for (int k = 0; k < 64 && !got; k++) begin
      @(negedge clk);
      got = ext_valid;
    end
    if (!got) begin
      chk(1'b0, "ext_timeout", 0, 1);
      exp_ext.delete();
    end
    tick();
    ext_req = 1'b0;
  endtask

  task automatic mem_compare(string name);
    int bad;
    bad = 0;
    for (int i = 0; i < NW; i++) if (sram[i] !== ref_mem[i]) bad++;
    chk(bad == 0, name, bad, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t, src, dst, r;
    logic [31:0] len;
    cpu_mem_read = 0; cpu_mem_write = 0; cpu_mem_copy = 0;
    cpu_addr = '0; cpu_wdata = '0;
    copy_src = '0; copy_dst = '0; copy_len = '0;
    ext_req = 0; ext_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk(ram_we == 0 && ram_addr == 0 && ram_wdata == 0, "reset_ram_port", ram_we, 0);
    chk(cpu_stall == 0 && copy_busy == 0, "reset_stall_busy", {cpu_stall, copy_busy}, 0);
    chk(copy_done == 0 && copy_err == 0 && ext_valid == 0, "reset_pulses",
        {copy_done, copy_err, ext_valid}, 0);
    chk(cpu_rdata == 0 && ext_rdata == 0, "reset_rdata", cpu_rdata | ext_rdata, 0);
    rst_n = 1'b1;

    for (int i = 0; i < NW; i++) cpu_cycle(1'b0, 1'b1, AW'(i), $urandom());
    cpu_cycle(0, 0, 0, 0);
    mem_compare("preload");

    // Forward copy with an external read held across it.
    for (int i = 0; i < 4; i++) cpu_cycle(1'b0, 1'b1, AW'(16 + i), 32'hA + i);
    fork
      do_copy(16, 32, 4, 1'b0);
      begin tick(); ext_read(9'd33, 1'b1); end
    join
    mem_compare("copy_fwd");
    for (int i = 0; i < 4; i++) chk(sram[32 + i] == 32'hA + i, "copy_fwd_word", sram[32 + i], 32'hA + i);

    // Overlapping copy must move the top word first.
    for (int i = 0; i < 4; i++) cpu_cycle(1'b0, 1'b1, AW'(10 + i), 32'(i + 1));
    do_copy(10, 12, 4, 1'b0);
    mem_compare("copy_overlap");
    for (int i = 0; i < 4; i++) chk(sram[12 + i] == 32'(i + 1), "overlap_word", sram[12 + i], i + 1);
    chk(sram[10] == 1 && sram[11] == 2, "overlap_low", {sram[10][7:0], sram[11][7:0]}, 16'h0102);

    do_copy(40, 60, 32'd0, 1'b0);
    do_copy(40, 60, 32'd600, 1'b0);
    do_copy(40, 60, 32'hFFFF_FFFF, 1'b0);
    mem_compare("copy_zero_reject");

    cpu_cycle(1'b0, 1'b1, 9'd7, 32'h55);
    cpu_cycle(1'b1, 1'b0, 9'd7, 32'h0);
    cpu_cycle(0, 0, 0, 0);

    do_copy(300, 200, 3, 1'b1);
    do_copy(5, 3, 32'd512, 1'b0);
    do_copy(508, 2, 10, 1'b0);
    cpu_cycle(0, 0, 0, 0);
    mem_compare("copy_edges");

    // Reset during the WR of word 2 of an 8-word copy.
    tick();
    t = cyc;
    cpu_mem_copy = 1'b1; copy_src = 32'd100; copy_dst = 32'd200; copy_len = 32'd8;
    exp_cp.push_back('{t + 17, 1'b0});
    st_lo = t; st_hi = t + 16; bz_lo = t + 1; bz_hi = t + 17;
    tick();
    cpu_mem_copy = 1'b0;
    while (cyc < t + 6) tick();
    rst_n = 1'b0;
    exp_cp.delete();
    st_lo = -1; st_hi = -2; bz_lo = -1; bz_hi = -2;
    #1;
    chk(ram_we == 0 && ram_addr == 0, "rst_mid_ram", ram_we, 0);
    chk(cpu_stall == 0 && copy_busy == 0 && copy_done == 0, "rst_mid_ctrl",
        {cpu_stall, copy_busy, copy_done}, 0);
    chk(cpu_rdata == 0 && ext_rdata == 0 && ext_valid == 0, "rst_mid_data", cpu_rdata | ext_rdata, 0);
    model_copy(100, 200, 8, 2);
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (4) cpu_cycle(0, 0, 0, 0);
    mem_compare("rst_mid_copy");

    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r < 4) cpu_cycle(1'b0, 1'b1, AW'($urandom()), $urandom());
      else if (r < 7) cpu_cycle(1'b1, 1'b0, AW'($urandom()), 32'h0);
      else if (r == 7) ext_read(AW'($urandom()), 1'b0);
      else begin
        src = $urandom_range(0, NW - 1);
        if ($urandom_range(0, 1) == 1) dst = (src + int'($urandom_range(0, 16)) - 8 + NW) % NW;
        else dst = $urandom_range(0, NW - 1);
        case ($urandom_range(0, 9))
          0:       len = 32'd0;
          1:       len = 32'd513 + $urandom_range(0, 1000);
          default: len = 32'($urandom_range(1, 12));
        endcase
        do_copy(src, dst, len, ($urandom_range(0, 3) == 0));
      end
    end
    repeat (3) cpu_cycle(0, 0, 0, 0);
    mem_compare("random_mem");
    chk(exp_ld.size() == 0 && exp_ext.size() == 0 && exp_cp.size() == 0, "queues_drained",
        exp_ld.size() + exp_ext.size() + exp_cp.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
